// File: rtl/burst_ram_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// burst_ram_arbiter_pkg
// Shared definitions for the BurstRAM request/grant arbiter:
//   - BurstRAM command encodings (CMD_READ / CMD_WRITE)
//   - arbiter state encoding (IDLE, GRANT, READ, WRITE, DRAIN)
//   - round-robin pick helper
// -----------------------------------------------------------------------------
package burst_ram_arbiter_pkg;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRANT = 3'd1,
    ST_READ  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DRAIN = 3'd4
  } arb_state_e;

  // Returns the winning requester index (0 = m0, 1 = m1). A lone requester
  // wins outright; on a tie the requester that did not own the RAM last wins.
  function automatic logic rr_pick(input logic req0, input logic req1,
                                   input logic rr_last);
    logic pick;
    if (req0 && req1) begin
      pick = ~rr_last;
    end else if (req1) begin
      pick = 1'b1;
    end else begin
      pick = 1'b0;
    end
    return pick;
  endfunction

endpackage

// File: rtl/burst_ram_arbiter.sv
// -----------------------------------------------------------------------------
// burst_ram_arbiter
// Shares one BurstRAM between two requesters (m0 = I-cache, m1 = D-cache).
// Round-robin request/grant; a grant covers exactly one burst command and is
// released automatically once the burst has finished and BurstRAM is idle.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   mN_req / mN_gnt         request in, registered grant out (N = 0,1)
//   mN_cmd, mN_cmd_en       command (0 read / 1 write) and its valid strobe
//   mN_addr, mN_wr_data     burst start address, write beat
//   mN_data_mask            byte mask, forwarded unchanged
//   mN_rd_data              BurstRAM read data, broadcast to both
//   mN_rd_data_ready        BurstRAM read strobe, only to the owner
//   mN_busy                 low only while owner may issue its command
//   br_*                    BurstRAM command side (owner mux) / response side
//   arb_err                 sticky watchdog revocation flag
//
// Optional feature: define BURST_ARB_WATCHDOG_EN to revoke a grant whose
// owner issues no command within WATCHDOG_CYCLES cycles. Without it the
// GRANT state waits indefinitely and arb_err is tied low.
// -----------------------------------------------------------------------------
module burst_ram_arbiter
  import burst_ram_arbiter_pkg::*;
#(
  parameter int DEPTH_BITWIDTH  = 4,
  parameter int BURST_COUNT     = 4,
  parameter int WATCHDOG_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      m0_req,
  output logic                      m0_gnt,
  input  logic                      m0_cmd,
  input  logic                      m0_cmd_en,
  input  logic [DEPTH_BITWIDTH-1:0] m0_addr,
  input  logic [63:0]               m0_wr_data,
  input  logic [7:0]                m0_data_mask,
  output logic [63:0]               m0_rd_data,
  output logic                      m0_rd_data_ready,
  output logic                      m0_busy,
  input  logic                      m1_req,
  output logic                      m1_gnt,
  input  logic                      m1_cmd,
  input  logic                      m1_cmd_en,
  input  logic [DEPTH_BITWIDTH-1:0] m1_addr,
  input  logic [63:0]               m1_wr_data,
  input  logic [7:0]                m1_data_mask,
  output logic [63:0]               m1_rd_data,
  output logic                      m1_rd_data_ready,
  output logic                      m1_busy,
  output logic                      br_cmd,
  output logic                      br_cmd_en,
  output logic [DEPTH_BITWIDTH-1:0] br_addr,
  output logic [63:0]               br_wr_data,
  output logic [7:0]                br_data_mask,
  input  logic [63:0]               br_rd_data,
  input  logic                      br_rd_data_ready,
  input  logic                      br_busy,
  output logic                      arb_err
);

  // Burst length must be a power of two, at least 2; watchdog must be nonzero.
  if (BURST_COUNT < 2 || (BURST_COUNT & (BURST_COUNT - 1)) != 0 ||
      WATCHDOG_CYCLES < 1) begin : g_bad_param
    $error("burst_ram_arbiter: invalid BURST_COUNT or WATCHDOG_CYCLES");
  end

  // One extra bit so the read count can reach BURST_COUNT without wrapping.
  localparam int BEAT_W = $clog2(BURST_COUNT) + 1;
  localparam logic [BEAT_W-1:0] BEAT_ONE     = BEAT_W'(1);
  localparam logic [BEAT_W-1:0] BEAT_RD_LAST = BEAT_W'(BURST_COUNT);
  localparam logic [BEAT_W-1:0] BEAT_WR_LAST = BEAT_W'(BURST_COUNT - 1);

  arb_state_e          state_q, state_d;
  logic                owner_q, owner_d;
  logic                rr_last_q, rr_last_d;
  logic [1:0]          gnt_q, gnt_d;
  logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic                own_cmd_en_s;
  logic                own_cmd_s;
  logic                wd_expire_s;

  // Owner mux: command side always follows the current owner.
  assign own_cmd_en_s = owner_q ? m1_cmd_en    : m0_cmd_en;
  assign own_cmd_s    = owner_q ? m1_cmd       : m0_cmd;
  assign br_cmd       = own_cmd_s;
  assign br_addr      = owner_q ? m1_addr      : m0_addr;
  assign br_wr_data   = owner_q ? m1_wr_data   : m0_wr_data;
  assign br_data_mask = owner_q ? m1_data_mask : m0_data_mask;
  // Only the owner's strobe, and only while waiting for its command.
  assign br_cmd_en    = (state_q == ST_GRANT) && own_cmd_en_s;

  assign m0_gnt           = gnt_q[0];
  assign m1_gnt           = gnt_q[1];
  assign m0_rd_data       = br_rd_data;
  assign m1_rd_data       = br_rd_data;
  assign m0_rd_data_ready = br_rd_data_ready && gnt_q[0];
  assign m1_rd_data_ready = br_rd_data_ready && gnt_q[1];
  assign m0_busy          = !(gnt_q[0] && (state_q == ST_GRANT));
  assign m1_busy          = !(gnt_q[1] && (state_q == ST_GRANT));

  // Arbiter next-state: grant, command capture, beat counting, release.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_last_d  = rr_last_q;
    gnt_d      = gnt_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (!br_busy && (m0_req || m1_req)) begin
          owner_d = rr_pick(m0_req, m1_req, rr_last_q);
          gnt_d   = owner_d ? 2'b10 : 2'b01;
          state_d = ST_GRANT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (own_cmd_en_s) begin
          beat_cnt_d = {BEAT_W{1'b0}};
          state_d    = (own_cmd_s == CMD_WRITE) ? ST_WRITE : ST_READ;
        end else if (wd_expire_s) begin
          state_d   = ST_IDLE;
          gnt_d     = 2'b00;
          rr_last_d = owner_q;
        end else begin
          state_d = ST_GRANT;
        end
      end
      ST_READ: begin
        if (br_rd_data_ready) begin
          beat_cnt_d = beat_cnt_q + BEAT_ONE;
          state_d    = (beat_cnt_d == BEAT_RD_LAST) ? ST_DRAIN : ST_READ;
        end else begin
          state_d = ST_READ;
        end
      end
      ST_WRITE: begin
        // Beat 0 went out with cmd_en; each WRITE cycle carries the next beat.
        beat_cnt_d = beat_cnt_q + BEAT_ONE;
        state_d    = (beat_cnt_d == BEAT_WR_LAST) ? ST_DRAIN : ST_WRITE;
      end
      ST_DRAIN: begin
        if (!br_busy) begin
          state_d   = ST_IDLE;
          gnt_d     = 2'b00;
          rr_last_d = owner_q;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= 1'b0;
      rr_last_q  <= 1'b1;
      gnt_q      <= 2'b00;
      beat_cnt_q <= {BEAT_W{1'b0}};
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_last_q  <= rr_last_d;
      gnt_q      <= gnt_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

`ifdef BURST_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(WATCHDOG_CYCLES) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            arb_err_q;

  // Watchdog counter: runs only while in GRANT, cleared everywhere else.
  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (state_q == ST_GRANT) begin
      wd_cnt_d = wd_cnt_q + WD_ONE;
    end else begin
      wd_cnt_d = {WD_W{1'b0}};
    end
  end

  assign wd_expire_s = (state_q == ST_GRANT) && !own_cmd_en_s &&
                       (wd_cnt_q == WD_LAST);

  // Watchdog counter and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_q  <= {WD_W{1'b0}};
      arb_err_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      arb_err_q <= arb_err_q | wd_expire_s;
    end
  end

  assign arb_err = arb_err_q;
`else
  assign wd_expire_s = 1'b0;
  assign arb_err     = 1'b0;
`endif

endmodule
